// File: rtl/mc_port_arbiter.sv
// Shares one MC request/response port among NUM_REQ requesters: round-robin request
// stage tagged with the requester ID, response demux by that ID, per-requester throttling.
module mc_port_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ID_W            = 2,
  parameter int MC_RTNCTL_WIDTH = 32,
  parameter int MAX_OUTST       = 4,
  localparam int UTAG_W         = MC_RTNCTL_WIDTH - ID_W
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_vld,
  output logic [NUM_REQ-1:0]           req_rdy,
  input  logic [3*NUM_REQ-1:0]         req_cmd,
  input  logic [4*NUM_REQ-1:0]         req_scmd,
  input  logic [48*NUM_REQ-1:0]        req_vadr,
  input  logic [2*NUM_REQ-1:0]         req_size,
  input  logic [UTAG_W*NUM_REQ-1:0]    req_rtnctl,
  input  logic [64*NUM_REQ-1:0]        req_data,
  output logic [NUM_REQ-1:0]           rsp_vld,
  output logic [2:0]                   rsp_cmd,
  output logic [3:0]                   rsp_scmd,
  output logic [UTAG_W-1:0]            rsp_rtnctl,
  output logic [63:0]                  rsp_data,
  input  logic [NUM_REQ-1:0]           rsp_stall,
  output logic                         mc_rq_vld,
  output logic [2:0]                   mc_rq_cmd,
  output logic [3:0]                   mc_rq_scmd,
  output logic [47:0]                  mc_rq_vadr,
  output logic [1:0]                   mc_rq_size,
  output logic [MC_RTNCTL_WIDTH-1:0]   mc_rq_rtnctl,
  output logic [63:0]                  mc_rq_data,
  output logic                         mc_rq_flush,
  input  logic                         mc_rq_stall,
  input  logic                         mc_rs_vld,
  input  logic [2:0]                   mc_rs_cmd,
  input  logic [3:0]                   mc_rs_scmd,
  input  logic [MC_RTNCTL_WIDTH-1:0]   mc_rs_rtnctl,
  input  logic [63:0]                  mc_rs_data,
  output logic                         mc_rs_stall
);

  localparam int NUM_SLOT = 1 << ID_W;
  localparam int CNT_W    = $clog2(MAX_OUTST + 1);

  logic [ID_W-1:0]     ptr;
  logic [CNT_W-1:0]    outst [NUM_REQ];
  logic [NUM_SLOT-1:0] eligible;
  logic                rq_free;
  logic                gnt_any;
  logic [ID_W-1:0]     gnt_id;
  logic [ID_W:0]       scan;
  logic [2:0]          sel_cmd;
  logic [3:0]          sel_scmd;
  logic [47:0]         sel_vadr;
  logic [1:0]          sel_size;
  logic [UTAG_W-1:0]   sel_tag;
  logic [63:0]         sel_data;
  logic [ID_W-1:0]     rs_id;
  logic [NUM_REQ-1:0]  rs_onehot;
  logic [NUM_REQ-1:0]  rsp_done;
  logic                rs_load;

  assign mc_rq_flush = 1'b0;
  assign rq_free     = !mc_rq_vld || !mc_rq_stall;

  // Eligibility is padded to a power of two so the scan can index it with ID_W bits.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_vld[i] && (outst[i] < CNT_W'(MAX_OUTST));
    end
  end

  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    scan    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, ptr} + (ID_W+1)'(k);
      if (scan >= (ID_W+1)'(NUM_REQ)) scan = scan - (ID_W+1)'(NUM_REQ);
      if (!gnt_any && eligible[scan[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_id  = scan[ID_W-1:0];
      end
    end
    if (!rq_free || !reset_n) gnt_any = 1'b0;
  end

  always_comb begin
    req_rdy  = '0;
    sel_cmd  = '0;
    sel_scmd = '0;
    sel_vadr = '0;
    sel_size = '0;
    sel_tag  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == ID_W'(i)) begin
        req_rdy[i] = gnt_any;
        sel_cmd    = req_cmd[3*i +: 3];
        sel_scmd   = req_scmd[4*i +: 4];
        sel_vadr   = req_vadr[48*i +: 48];
        sel_size   = req_size[2*i +: 2];
        sel_tag    = req_rtnctl[UTAG_W*i +: UTAG_W];
        sel_data   = req_data[64*i +: 64];
      end
    end
  end

  // Request stage: payload only changes on a grant; an idle free cycle just drops valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr          <= '0;
      mc_rq_vld    <= 1'b0;
      mc_rq_cmd    <= '0;
      mc_rq_scmd   <= '0;
      mc_rq_vadr   <= '0;
      mc_rq_size   <= '0;
      mc_rq_rtnctl <= '0;
      mc_rq_data   <= '0;
    end else if (gnt_any) begin
      ptr          <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      mc_rq_vld    <= 1'b1;
      mc_rq_cmd    <= sel_cmd;
      mc_rq_scmd   <= sel_scmd;
      mc_rq_vadr   <= sel_vadr;
      mc_rq_size   <= sel_size;
      mc_rq_rtnctl <= {gnt_id, sel_tag};
      mc_rq_data   <= sel_data;
    end else if (rq_free) begin
      mc_rq_vld    <= 1'b0;
    end
  end

  assign rs_id       = mc_rs_rtnctl[MC_RTNCTL_WIDTH-1 -: ID_W];
  assign rsp_done    = rsp_vld & ~rsp_stall;
  assign mc_rs_stall = |(rsp_vld & rsp_stall);
  assign rs_load     = mc_rs_vld && !mc_rs_stall;

  // An ID with no matching requester decodes to all-zero and is therefore dropped.
  always_comb begin
    rs_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rs_onehot[i] = (rs_id == ID_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_vld    <= '0;
      rsp_cmd    <= '0;
      rsp_scmd   <= '0;
      rsp_rtnctl <= '0;
      rsp_data   <= '0;
    end else if (rs_load && |rs_onehot) begin
      rsp_vld    <= rs_onehot;
      rsp_cmd    <= mc_rs_cmd;
      rsp_scmd   <= mc_rs_scmd;
      rsp_rtnctl <= mc_rs_rtnctl[UTAG_W-1:0];
      rsp_data   <= mc_rs_data;
    end else if (!mc_rs_stall) begin
      rsp_vld    <= '0;
    end
  end

  // A delivery with nothing outstanding is a protocol error; the counter holds at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) outst[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_rdy[i] && !rsp_done[i]) begin
          outst[i] <= outst[i] + 1'b1;
        end else if (!req_rdy[i] && rsp_done[i] && outst[i] != '0) begin
          outst[i] <= outst[i] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mc_port_arbiter.sv
// Randomized bench for mc_port_arbiter: the bench plays requesters and the MC, and a
// transaction-level model predicts grants, MC requests and demuxed responses.
module tb_mc_port_arbiter;

  localparam int NR   = 4;
  localparam int IDW  = 2;
  localparam int RW   = 32;
  localparam int UW   = RW - IDW;
  localparam int MAXO = 4;

  logic              clk;
  logic              reset_n;
  logic [NR-1:0]     req_vld, req_rdy;
  logic [3*NR-1:0]   req_cmd;
  logic [4*NR-1:0]   req_scmd;
  logic [48*NR-1:0]  req_vadr;
  logic [2*NR-1:0]   req_size;
  logic [UW*NR-1:0]  req_rtnctl;
  logic [64*NR-1:0]  req_data;
  logic [NR-1:0]     rsp_vld, rsp_stall;
  logic [2:0]        rsp_cmd;
  logic [3:0]        rsp_scmd;
  logic [UW-1:0]     rsp_rtnctl;
  logic [63:0]       rsp_data;
  logic              mc_rq_vld, mc_rq_flush, mc_rq_stall;
  logic [2:0]        mc_rq_cmd;
  logic [3:0]        mc_rq_scmd;
  logic [47:0]       mc_rq_vadr;
  logic [1:0]        mc_rq_size;
  logic [RW-1:0]     mc_rq_rtnctl;
  logic [63:0]       mc_rq_data;
  logic              mc_rs_vld, mc_rs_stall;
  logic [2:0]        mc_rs_cmd;
  logic [3:0]        mc_rs_scmd;
  logic [RW-1:0]     mc_rs_rtnctl;
  logic [63:0]       mc_rs_data;

  int n_checks = 0;
  int n_errors = 0;
  int p_req, p_rq_stall, p_rsp_stall, p_mc_rs;

  int           m_ptr;
  int           m_outst [NR];
  bit           m_rq_vld;
  logic [2:0]   m_rq_cmd;
  logic [3:0]   m_rq_scmd;
  logic [47:0]  m_rq_vadr;
  logic [1:0]   m_rq_size;
  logic [RW-1:0] m_rq_rtnctl;
  logic [63:0]  m_rq_data;
  bit           m_rs_vld;
  int           m_rs_id;
  logic [2:0]   m_rs_cmd;
  logic [3:0]   m_rs_scmd;
  logic [UW-1:0] m_rs_tag;
  logic [63:0]  m_rs_data;

  logic [RW-1:0] mc_q [$];
  bit            rs_consumed;

  mc_port_arbiter #(.NUM_REQ(NR), .ID_W(IDW), .MC_RTNCTL_WIDTH(RW), .MAX_OUTST(MAXO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_cmd(req_cmd), .req_scmd(req_scmd),
    .req_vadr(req_vadr), .req_size(req_size), .req_rtnctl(req_rtnctl), .req_data(req_data),
    .rsp_vld(rsp_vld), .rsp_cmd(rsp_cmd), .rsp_scmd(rsp_scmd), .rsp_rtnctl(rsp_rtnctl),
    .rsp_data(rsp_data), .rsp_stall(rsp_stall),
    .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd),
    .mc_rq_vadr(mc_rq_vadr), .mc_rq_size(mc_rq_size), .mc_rq_rtnctl(mc_rq_rtnctl),
    .mc_rq_data(mc_rq_data), .mc_rq_flush(mc_rq_flush), .mc_rq_stall(mc_rq_stall),
    .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd), .mc_rs_scmd(mc_rs_scmd),
    .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_data(mc_rs_data), .mc_rs_stall(mc_rs_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(99) < p;
  endfunction

  // Async reset also drops whatever the bench-side MC had accepted but not answered.
  task automatic model_reset();
    m_ptr    = 0;
    foreach (m_outst[i]) m_outst[i] = 0;
    m_rq_vld = 1'b0;
    m_rs_vld = 1'b0;
    m_rs_id  = 0;
    mc_q.delete();
    mc_rs_vld   = 1'b0;
    rs_consumed = 1'b0;
  endtask

  task automatic applyStimulus();
    if (rs_consumed) begin
      mc_rs_vld   = 1'b0;
      rs_consumed = 1'b0;
    end
    for (int i = 0; i < NR; i++) begin
      req_vld[i]              = pct(p_req);
      req_cmd[3*i +: 3]       = 3'($urandom);
      req_scmd[4*i +: 4]      = 4'($urandom);
      req_vadr[48*i +: 48]    = 48'({$urandom, $urandom});
      req_size[2*i +: 2]      = 2'($urandom);
      req_rtnctl[UW*i +: UW]  = UW'($urandom);
      req_data[64*i +: 64]    = {$urandom, $urandom};
      rsp_stall[i]            = pct(p_rsp_stall);
    end
    mc_rq_stall = pct(p_rq_stall);
    if (!mc_rs_vld && reset_n && mc_q.size() > 0 && pct(p_mc_rs)) begin
      mc_rs_vld    = 1'b1;
      mc_rs_rtnctl = mc_q.pop_front();
      mc_rs_cmd    = 3'($urandom);
      mc_rs_scmd   = 4'($urandom);
      mc_rs_data   = {$urandom, $urandom};
    end
  endtask

  // Compares the DUT against the model for the current cycle, then advances the model
  // by the clock edge that follows, using the inputs that are now being applied.
  task automatic check_and_step();
    bit            free, exp_rs_stall, deliver;
    int            gid;
    logic [NR-1:0] exp_rdy;
    free = !m_rq_vld || !mc_rq_stall;
    gid  = -1;
    if (reset_n && free) begin
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (m_ptr + k) % NR;
        if (gid < 0 && req_vld[i] && m_outst[i] < MAXO) gid = i;
      end
    end
    exp_rdy      = (gid >= 0) ? NR'(1 << gid) : '0;
    exp_rs_stall = m_rs_vld && rsp_stall[m_rs_id];

    checkOutput("req_rdy", req_rdy, exp_rdy);
    checkOutput("mc_rs_stall", mc_rs_stall, exp_rs_stall);
    checkOutput("mc_rq_vld", mc_rq_vld, m_rq_vld);
    checkOutput("mc_rq_flush", mc_rq_flush, 0);
    checkOutput("rsp_vld", rsp_vld, m_rs_vld ? (64'd1 << m_rs_id) : 64'd0);
    if (m_rq_vld) begin
      checkOutput("mc_rq_cmd", mc_rq_cmd, m_rq_cmd);
      checkOutput("mc_rq_scmd", mc_rq_scmd, m_rq_scmd);
      checkOutput("mc_rq_vadr", mc_rq_vadr, m_rq_vadr);
      checkOutput("mc_rq_size", mc_rq_size, m_rq_size);
      checkOutput("mc_rq_rtnctl", mc_rq_rtnctl, m_rq_rtnctl);
      checkOutput("mc_rq_data", mc_rq_data, m_rq_data);
    end
    if (m_rs_vld) begin
      checkOutput("rsp_cmd", rsp_cmd, m_rs_cmd);
      checkOutput("rsp_scmd", rsp_scmd, m_rs_scmd);
      checkOutput("rsp_rtnctl", rsp_rtnctl, m_rs_tag);
      checkOutput("rsp_data", rsp_data, m_rs_data);
    end
    if (!reset_n) begin
      checkOutput("rst_rq_rtnctl", mc_rq_rtnctl, 0);
      checkOutput("rst_rq_data", mc_rq_data, 0);
      checkOutput("rst_rsp_rtnctl", rsp_rtnctl, 0);
      checkOutput("rst_rsp_data", rsp_data, 0);
      return;
    end

    deliver     = m_rs_vld && !rsp_stall[m_rs_id];
    rs_consumed = mc_rs_vld && !exp_rs_stall;
    if (m_rq_vld && !mc_rq_stall) mc_q.push_back(m_rq_rtnctl);

    if (gid >= 0) m_outst[gid]++;
    if (deliver && m_outst[m_rs_id] > 0) m_outst[m_rs_id]--;

    if (rs_consumed) begin
      m_rs_vld  = 1'b1;
      m_rs_id   = int'(mc_rs_rtnctl[RW-1 -: IDW]);
      m_rs_cmd  = mc_rs_cmd;
      m_rs_scmd = mc_rs_scmd;
      m_rs_tag  = mc_rs_rtnctl[UW-1:0];
      m_rs_data = mc_rs_data;
    end else if (deliver) begin
      m_rs_vld = 1'b0;
    end

    if (gid >= 0) begin
      m_rq_vld    = 1'b1;
      m_rq_cmd    = req_cmd[3*gid +: 3];
      m_rq_scmd   = req_scmd[4*gid +: 4];
      m_rq_vadr   = req_vadr[48*gid +: 48];
      m_rq_size   = req_size[2*gid +: 2];
      m_rq_rtnctl = {IDW'(gid), req_rtnctl[UW*gid +: UW]};
      m_rq_data   = req_data[64*gid +: 64];
      m_ptr       = (gid + 1) % NR;
    end else if (free) begin
      m_rq_vld = 1'b0;
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      applyStimulus();
      #1;
      check_and_step();
      @(negedge clk);
    end
  endtask

  task automatic set_knobs(input int rq, input int rqs, input int rss, input int mcr);
    p_req       = rq;
    p_rq_stall  = rqs;
    p_rsp_stall = rss;
    p_mc_rs     = mcr;
  endtask

  initial begin
    reset_n      = 1'b0;
    req_vld      = '0;
    req_cmd      = '0;
    req_scmd     = '0;
    req_vadr     = '0;
    req_size     = '0;
    req_rtnctl   = '0;
    req_data     = '0;
    rsp_stall    = '0;
    mc_rq_stall  = 1'b0;
    mc_rs_vld    = 1'b0;
    mc_rs_cmd    = '0;
    mc_rs_scmd   = '0;
    mc_rs_rtnctl = '0;
    mc_rs_data   = '0;
    set_knobs(0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    run_cycles(2);
    reset_n = 1'b1;

    // Single RD8 from requester 0 with tag 5, echoed straight back by the MC.
    set_knobs(0, 0, 0, 100);
    applyStimulus();
    req_vld              = 4'b0001;
    req_cmd[2:0]         = 3'd1;
    req_vadr[47:0]       = 48'h10;
    req_rtnctl[UW-1:0]   = UW'(5);
    #1;
    check_and_step();
    @(negedge clk);
    applyStimulus();
    #1;
    checkOutput("t1_rq_vld", mc_rq_vld, 1);
    checkOutput("t1_rq_rtnctl", mc_rq_rtnctl, 32'd5);
    checkOutput("t1_rq_vadr", mc_rq_vadr, 48'h10);
    check_and_step();
    @(negedge clk);
    run_cycles(6);

    // Everyone requesting with no responses: round-robin until every counter saturates.
    set_knobs(100, 0, 0, 0);
    run_cycles(20);
    set_knobs(100, 0, 0, 100);
    run_cycles(30);

    set_knobs(60, 25, 25, 50);
    run_cycles(1500);
    set_knobs(80, 70, 60, 70);
    run_cycles(300);

    // Reset asserted in the middle of a busy burst, then a fresh start.
    set_knobs(100, 20, 20, 50);
    run_cycles(8);
    reset_n = 1'b0;
    model_reset();
    run_cycles(3);
    reset_n = 1'b1;
    set_knobs(100, 0, 0, 100);
    run_cycles(12);
    set_knobs(50, 30, 30, 60);
    run_cycles(300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
